seg7_scan_driver: RTL

- Parametrised, time-multiplexed N-digit 7-segment display driver.
- Successor to the single-digit BCD decoder. Adds hex mode, frame-synchronous double-buffered value loading, digit scanning with anti-ghosting dead time, and blanking.
- Sits between system logic (which supplies packed nibbles) and the board's shared segment bus and per-digit anode enables.

---
 rtl/seg7_scan_driver.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-synchronous double buffering,
// anti-ghosting dead time and blanking. Define SEG7_LZ_SUPPRESS_EN for leading-zero suppression.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SHOW_CYCLES    = 50000,
  parameter int GAP_CYCLES     = 500,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int DW      = 4 * NUM_DIGITS;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  typedef enum logic {S_SHOW, S_GAP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DW-1:0]           pending_q, pending_d;
  logic [DW-1:0]           shadow_q, shadow_d;
  logic                    dirty_q, dirty_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_start_q, frame_start_d;

  logic                    digit_end;
  logic [3:0]              digit_nib;
  logic                    digit_lit;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [6:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   an_raw;
`ifdef SEG7_LZ_SUPPRESS_EN
  logic                    nz_acc;
`endif

  function automatic logic [6:0] decode7(input logic [3:0] nib, input logic hex);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = hex ? 7'b1110111 : 7'b0000000;
      4'hB: s = hex ? 7'b0011111 : 7'b0000000;
      4'hC: s = hex ? 7'b1001110 : 7'b0000000;
      4'hD: s = hex ? 7'b0111101 : 7'b0000000;
      4'hE: s = hex ? 7'b1001111 : 7'b0000000;
      default: s = hex ? 7'b1000111 : 7'b0000000;
    endcase
    return s;
  endfunction

  // Scan sequencing and buffer transfer.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    dirty_d   = dirty_q;
    digit_end = 1'b0;

    case (state_q)
      S_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d = '0;
          if (GAP_CYCLES == 0) digit_end = 1'b1;
          else                 state_d   = S_GAP;
        end
      end
      default: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d     = '0;
          digit_end = 1'b1;
        end
      end
    endcase

    if (digit_end) begin
      state_d = S_SHOW;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        // Frame boundary: the only point the displayed image may change.
        if (dirty_q) begin
          shadow_d = pending_q;
          dirty_d  = 1'b0;
        end
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    // A load on the transfer edge wins the dirty flag, so the new value waits one frame.
    if (load) begin
      pending_d = value;
      dirty_d   = 1'b1;
    end
  end

  // Digit selection and registered output images.
  always_comb begin
    digit_nib = 4'h0;
    digit_lit = 1'b1;
    an_sel    = '0;
`ifdef SEG7_LZ_SUPPRESS_EN
    nz_acc    = 1'b0;
`endif
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
`ifdef SEG7_LZ_SUPPRESS_EN
      nz_acc = nz_acc | (shadow_q[4*i +: 4] != 4'h0);
`endif
      an_sel[i] = (idx_q == IDX_W'(i));
      if (idx_q == IDX_W'(i)) begin
        digit_nib = shadow_q[4*i +: 4];
`ifdef SEG7_LZ_SUPPRESS_EN
        digit_lit = nz_acc || (i == 0);
`endif
      end
    end

    seg_raw = 7'b0000000;
    an_raw  = '0;
    if (state_q == S_SHOW && !blank) begin
      seg_raw = decode7(digit_nib, hex_mode);
      an_raw  = digit_lit ? an_sel : '0;
    end

    seg_d         = seg_raw ^ SEG_OFF;
    an_d          = an_raw ^ AN_OFF;
    frame_start_d = (state_q == S_SHOW) && (idx_q == '0) && (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_SHOW;
      cnt_q         <= '0;
      idx_q         <= '0;
      // NOTE: the buffers are plain flops and are reset so the first frame shows a defined zero.
      pending_q     <= '0;
      shadow_q      <= '0;
      dirty_q       <= 1'b0;
      seg_q         <= SEG_OFF;
      an_q          <= AN_OFF;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make every flop sample the pre-edge values of the others.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      shadow_q      <= shadow_d;
      dirty_q       <= dirty_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule
